dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/mem_if_pkg.sv | 23 ++
 rtl/dmem_array.sv | 38 +++
 rtl/dmem_responder.sv | 149 ++++++++++++++
 tb/tb_dmem_responder.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// default geometry/latency and the access-error rule.
package mem_if_pkg;

  localparam int unsigned DEPTH_WORDS_DEF = 256;
  localparam int unsigned LATENCY_DEF     = 2;
  // Wide enough for the largest legal latency (15).
  localparam int unsigned CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // An access faults when it is not word aligned or its word index lies
  // outside the array.
  function automatic logic is_access_err(input logic [31:0] addr,
                                         input int unsigned depth_words);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth_words);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage: synchronous write, combinational read.
// Byte-granular write enables exist only when DMEM_WSTRB_EN is defined.
module dmem_array
  import mem_if_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
`ifdef DMEM_WSTRB_EN
  input  logic [3:0]    be_i,
`endif
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  // Write the addressed word (or only its enabled bytes) on the rising edge.
  // NOTE: the array has no reset branch; contents must survive reset and a
  // reset on a memory would also stop it mapping onto RAM macros.
  always_ff @(posedge clk) begin
    if (we_i) begin
`ifdef DMEM_WSTRB_EN
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
`else
      mem_q[addr_i] <= wdata_i;
`endif
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder. One request is accepted in IDLE,
// held in WAIT for exactly LATENCY cycles, and presented in RESP until the
// initiator takes it. Define DMEM_WSTRB_EN to add the req_wstrb port and
// byte-granular stores; without it every store writes the whole word.
module dmem_responder
  import mem_if_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int unsigned LATENCY     = LATENCY_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
`ifdef DMEM_WSTRB_EN
  input  logic [3:0]  req_wstrb,
`endif
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             access;

  logic             we_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
`ifdef DMEM_WSTRB_EN
  logic [3:0]       wstrb_q;
`endif

  logic [31:0]      rdata_q;
  logic             err_q;
  logic [31:0]      arr_rdata;
  logic             acc_err;
  logic             arr_we;

  // Next-state, latency counter and handshake decode.
  // NOTE: every output of this block gets a default first so no path leaves
  // it unassigned, which is what would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    accept    = 1'b0;
    access    = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept  = 1'b1;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          access  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers.
  // NOTE: clocked state uses non-blocking assignment so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the request fields on accept; later req_* activity is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef DMEM_WSTRB_EN
      wstrb_q <= '0;
`endif
    end else if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
`ifdef DMEM_WSTRB_EN
      wstrb_q <= req_wstrb;
`endif
    end
  end

  assign acc_err = is_access_err(addr_q, DEPTH_WORDS);
  // Faulting or reset-aborted stores never reach the array.
  assign arr_we  = access && we_q && !acc_err;

  // Response payload: loaded when the access fires, held through RESP,
  // cleared once the initiator has taken it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (access) begin
      err_q   <= acc_err;
      rdata_q <= (acc_err || we_q) ? '0 : arr_rdata;
    end else if ((state_q == RESP) && rsp_ready) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk     (clk),
    .we_i    (arr_we),
    .addr_i  (addr_q[AW+1:2]),
    .wdata_i (wdata_q),
`ifdef DMEM_WSTRB_EN
    .be_i    (wstrb_q),
`endif
    .rdata_o (arr_rdata)
  );

  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a reference word model and an
// expected-response queue. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_dmem_responder;

  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
`ifdef DMEM_WSTRB_EN
  logic [3:0]  req_wstrb;
`endif
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model_mem [int unsigned];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
`ifdef DMEM_WSTRB_EN
    .req_wstrb (req_wstrb),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  // Reference behaviour: error rule, byte merge, load of stored data.
  task automatic model_req(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb,
                           output exp_t e);
    logic [3:0]  be;
    logic [31:0] word;
    int unsigned idx;
`ifdef DMEM_WSTRB_EN
    be = wstrb;
`else
    be = 4'hF;
`endif
    idx     = addr >> 2;
    e.err   = (addr[1:0] != 2'b00) || (idx >= DEPTH);
    e.rdata = 32'h0;
    if (!e.err) begin
      word = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) word[8*b +: 8] = wdata[8*b +: 8];
        end
        model_mem[idx] = word;
      end else begin
        e.rdata = word;
      end
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic send_req(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb,
                          input bit drop);
    int   n = 0;
    exp_t e;
    while (!req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("req_ready_wait", 32'(req_ready), 32'h1);
    end else begin
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
`ifdef DMEM_WSTRB_EN
      req_wstrb = wstrb;
`endif
      if (!drop) begin
        model_req(we, addr, wdata, wstrb, e);
        sb_q.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  // Counts rising edges from the accept until rsp_valid is seen.
  task automatic wait_rsp(input string tag, output int lat);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (rsp_valid) break;
    end
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h1);
  endtask

  task automatic take_rsp(input string tag);
    exp_t e;
    check({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'h1);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({tag, "_rdata"}, rsp_rdata, e.rdata);
      check({tag, "_err"}, 32'(rsp_err), 32'(e.err));
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_valid_dropped"}, 32'(rsp_valid), 32'h0);
    check({tag, "_ready_back"}, 32'(req_ready), 32'h1);
  endtask

  task automatic txn(input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] wstrb,
                     input string tag);
    int lat;
    send_req(we, addr, wdata, wstrb, 1'b0);
    wait_rsp(tag, lat);
    check({tag, "_latency"}, 32'(lat), 32'(LAT));
    take_rsp(tag);
  endtask

  initial begin
    exp_t e;
    int   lat;
    int   acc_cyc[3];
    int   n_acc;
    int   n_rsp;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
`ifdef DMEM_WSTRB_EN
    req_wstrb = '0;
`endif
    rsp_ready = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", 32'(rsp_err), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", 32'(req_ready), 32'h1);
    check("post_rst_rsp_valid", 32'(rsp_valid), 32'h0);

    // Store then load the same word, exact latency.
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "st_10");
    txn(1'b0, 32'h10, 32'h0, 4'hF, "ld_10");

    // Misaligned load, out-of-range store, word 0 untouched.
    txn(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, "st_0");
    txn(1'b0, 32'h13, 32'h0, 4'hF, "ld_13_misaligned");
    txn(1'b1, 32'h400, 32'h11111111, 4'hF, "st_400_oor");
    txn(1'b0, 32'h0, 32'h0, 4'hF, "ld_0_after_oor");

    // Last valid word.
    txn(1'b1, 32'h3FC, 32'hA5A55A5A, 4'hF, "st_last");
    txn(1'b0, 32'h3FC, 32'h0, 4'hF, "ld_last");

    // Response stall: five cycles with rsp_ready low while a stray store
    // request is presented; everything must hold and the store be ignored.
    send_req(1'b0, 32'h10, 32'h0, 4'hF, 1'b0);
    wait_rsp("stall", lat);
    check("stall_latency", 32'(lat), 32'(LAT));
    e = sb_q.pop_front();
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h10;
    req_wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("stall_rsp_valid", 32'(rsp_valid), 32'h1);
      check("stall_rsp_rdata", rsp_rdata, e.rdata);
      check("stall_rsp_err", 32'(rsp_err), 32'(e.err));
      check("stall_req_ready", 32'(req_ready), 32'h0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("stall_released", 32'(rsp_valid), 32'h0);
    txn(1'b0, 32'h10, 32'h0, 4'hF, "ld_10_after_stall");

    // Reset one cycle after accepting a store: the store must be discarded.
    txn(1'b1, 32'h20, 32'h11223344, 4'hF, "st_20");
    send_req(1'b1, 32'h20, 32'h12345678, 4'hF, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("wait_rsp_valid", 32'(rsp_valid), 32'h0);
    rst = 1'b1;
    #1;
    check("rst_wait_rsp_valid", 32'(rsp_valid), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_wait_req_ready", 32'(req_ready), 32'h1);
    txn(1'b0, 32'h20, 32'h0, 4'hF, "ld_20_after_rst");

    // Reset while a response is being presented: dropped without handshake.
    send_req(1'b0, 32'h10, 32'h0, 4'hF, 1'b1);
    wait_rsp("rst_resp", lat);
    check("rst_resp_rdata_before", rsp_rdata, 32'hDEADBEEF);
    rst = 1'b1;
    #1;
    check("rst_resp_valid", 32'(rsp_valid), 32'h0);
    check("rst_resp_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_resp_req_ready", 32'(req_ready), 32'h1);
    check("rst_resp_valid_after", 32'(rsp_valid), 32'h0);

    // Back-to-back loads with both sides always ready: accept spacing.
    n_acc     = 0;
    n_rsp     = 0;
    req_we    = 1'b0;
    req_addr  = 32'h10;
    req_wdata = 32'h0;
`ifdef DMEM_WSTRB_EN
    req_wstrb = 4'hF;
`endif
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    for (int cyc = 0; cyc < 24; cyc++) begin
      if (rsp_valid) begin
        check("b2b_sb_nonempty", 32'(sb_q.size() != 0), 32'h1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("b2b_rdata", rsp_rdata, e.rdata);
          check("b2b_err", 32'(rsp_err), 32'(e.err));
        end
        n_rsp++;
      end
      if (n_acc >= 3) begin
        req_valid = 1'b0;
      end else if (req_ready) begin
        model_req(1'b0, 32'h10, 32'h0, 4'hF, e);
        sb_q.push_back(e);
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check("b2b_accepts", 32'(n_acc), 32'h3);
    check("b2b_responses", 32'(n_rsp), 32'h3);
    check("b2b_spacing_01", 32'(acc_cyc[1] - acc_cyc[0]), 32'(LAT + 2));
    check("b2b_spacing_12", 32'(acc_cyc[2] - acc_cyc[1]), 32'(LAT + 2));

`ifdef DMEM_WSTRB_EN
    // Byte-enable stores, including an all-zero strobe no-op.
    txn(1'b1, 32'h8, 32'hFFFFFFFF, 4'hF, "st_8_full");
    txn(1'b1, 32'h8, 32'h000000AA, 4'h1, "st_8_byte0");
    txn(1'b1, 32'h8, 32'h12345678, 4'h0, "st_8_noop");
    txn(1'b0, 32'h8, 32'h0, 4'hF, "ld_8_merged");
`else
    // Without byte enables a store replaces the whole word.
    txn(1'b1, 32'h8, 32'hFFFFFFFF, 4'hF, "st_8_full");
    txn(1'b1, 32'h8, 32'h000000AA, 4'h1, "st_8_word");
    txn(1'b0, 32'h8, 32'h0, 4'hF, "ld_8_word");
`endif

    check("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
